// File: rtl/sync_fifo_pkg.sv
// Shared types and helpers for the show-ahead synchronous FIFO.
// Pointer wrap is an explicit compare, so Depth need not be a power of two.
package sync_fifo_pkg;

    typedef struct packed {
        logic full;
        logic empty;
        logic almost_full;
        logic almost_empty;
    } fifo_flags_t;

    function automatic int unsigned ptr_inc(input int unsigned ptr, input int unsigned depth);
        return (ptr == depth - 1) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/sync_fifo_ram.sv
// FIFO storage: synchronous write, asynchronous (show-ahead) read, no reset.
module sync_fifo_ram #(
    parameter int DataWidth = 8,
    parameter int Depth     = 8
) (
    input  logic                       i_clk,
    input  logic                       i_wr_en,
    input  logic [$clog2(Depth)-1:0]   i_wr_addr,
    input  logic [DataWidth-1:0]       i_wr_data,
    input  logic [$clog2(Depth)-1:0]   i_rd_addr,
    output logic [DataWidth-1:0]       o_rd_data
);

    logic [DataWidth-1:0] mem [Depth];

    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            mem[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_data = mem[i_rd_addr];

endmodule

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO: pointers, occupancy counter and registered status flags.
// Optional sticky overflow/underflow flags are built when SYNC_FIFO_ERR_FLAGS_EN is defined.
module sync_fifo
    import sync_fifo_pkg::*;
#(
    parameter int DataWidth        = 8,
    parameter int Depth            = 8,
    parameter int AlmostFullLevel  = Depth - 1,
    parameter int AlmostEmptyLevel = 1
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    input  logic                         i_wr_en,
    input  logic [DataWidth-1:0]         i_wr_data,
    input  logic                         i_rd_en,
    output logic [DataWidth-1:0]         o_rd_data,
    output logic                         o_full,
    output logic                         o_empty,
    output logic                         o_almost_full,
    output logic                         o_almost_empty,
    output logic [$clog2(Depth+1)-1:0]   o_count
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    ,
    input  logic                         i_err_clr,
    output logic                         o_overflow,
    output logic                         o_underflow
`endif
);

    localparam int AddrWidth  = $clog2(Depth);
    localparam int CountWidth = $clog2(Depth+1);

    localparam logic [CountWidth-1:0] DepthCnt = CountWidth'(Depth);
    localparam logic [CountWidth-1:0] AfLevel  = CountWidth'(AlmostFullLevel);
    localparam logic [CountWidth-1:0] AeLevel  = CountWidth'(AlmostEmptyLevel);

    logic [AddrWidth-1:0]  wr_ptr;
    logic [AddrWidth-1:0]  rd_ptr;
    logic [CountWidth-1:0] count;
    logic [CountWidth-1:0] count_nxt;
    fifo_flags_t           flags;
    fifo_flags_t           flags_nxt;
    logic                  push_acc;
    logic                  pop_acc;

    // A push into a full FIFO is only legal when a pop frees the head slot in the same cycle.
    assign pop_acc  = i_rd_en & ~flags.empty;
    assign push_acc = i_wr_en & (~flags.full | pop_acc);

    always_comb begin
        count_nxt = count;
        case ({push_acc, pop_acc})
            2'b10:   count_nxt = count + 1'b1;
            2'b01:   count_nxt = count - 1'b1;
            default: count_nxt = count;
        endcase

        flags_nxt              = '0;
        flags_nxt.full         = (count_nxt == DepthCnt);
        flags_nxt.empty        = (count_nxt == '0);
        flags_nxt.almost_full  = (count_nxt >= AfLevel);
        flags_nxt.almost_empty = (count_nxt <= AeLevel);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr             <= '0;
            rd_ptr             <= '0;
            count              <= '0;
            flags.full         <= 1'b0;
            flags.empty        <= 1'b1;
            flags.almost_full  <= (AlmostFullLevel == 0);
            flags.almost_empty <= 1'b1;
        end else begin
            if (push_acc) begin
                wr_ptr <= AddrWidth'(ptr_inc(32'(wr_ptr), 32'(Depth)));
            end
            if (pop_acc) begin
                rd_ptr <= AddrWidth'(ptr_inc(32'(rd_ptr), 32'(Depth)));
            end
            count <= count_nxt;
            flags <= flags_nxt;
        end
    end

    sync_fifo_ram #(
        .DataWidth (DataWidth),
        .Depth     (Depth)
    ) u_ram (
        .i_clk     (i_clk),
        .i_wr_en   (push_acc),
        .i_wr_addr (wr_ptr),
        .i_wr_data (i_wr_data),
        .i_rd_addr (rd_ptr),
        .o_rd_data (o_rd_data)
    );

    assign o_full         = flags.full;
    assign o_empty        = flags.empty;
    assign o_almost_full  = flags.almost_full;
    assign o_almost_empty = flags.almost_empty;
    assign o_count        = count;

`ifdef SYNC_FIFO_ERR_FLAGS_EN
    logic overflow_q;
    logic underflow_q;

    // Set wins over a simultaneous clear so no rejected request is ever lost.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (i_wr_en & ~push_acc) begin
                overflow_q <= 1'b1;
            end else if (i_err_clr) begin
                overflow_q <= 1'b0;
            end
            if (i_rd_en & ~pop_acc) begin
                underflow_q <= 1'b1;
            end else if (i_err_clr) begin
                underflow_q <= 1'b0;
            end
        end
    end

    assign o_overflow  = overflow_q;
    assign o_underflow = underflow_q;
`endif

endmodule

// File: tb/tb_sync_fifo.sv
// Directed self-checking bench for sync_fifo: a Depth=8 and a Depth=5 instance.
module tb_sync_fifo;

    logic       clk;
    logic       rst_n;

    logic       wr8, rd8;
    logic [7:0] wd8, rdata8;
    logic       full8, empty8, af8, ae8;
    logic [3:0] cnt8;

    logic       wr5, rd5;
    logic [7:0] wd5, rdata5;
    logic       full5, empty5, af5, ae5;
    logic [2:0] cnt5;

`ifdef SYNC_FIFO_ERR_FLAGS_EN
    logic       clr8, ovf8, unf8;
    logic       clr5, ovf5, unf5;
`endif

    int checks = 0;
    int errors = 0;

    sync_fifo #(.DataWidth(8), .Depth(8)) u_dut8 (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_wr_en        (wr8),
        .i_wr_data      (wd8),
        .i_rd_en        (rd8),
        .o_rd_data      (rdata8),
        .o_full         (full8),
        .o_empty        (empty8),
        .o_almost_full  (af8),
        .o_almost_empty (ae8),
        .o_count        (cnt8)
`ifdef SYNC_FIFO_ERR_FLAGS_EN
        ,
        .i_err_clr      (clr8),
        .o_overflow     (ovf8),
        .o_underflow    (unf8)
`endif
    );

    sync_fifo #(.DataWidth(8), .Depth(5)) u_dut5 (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_wr_en        (wr5),
        .i_wr_data      (wd5),
        .i_rd_en        (rd5),
        .o_rd_data      (rdata5),
        .o_full         (full5),
        .o_empty        (empty5),
        .o_almost_full  (af5),
        .o_almost_empty (ae5),
        .o_count        (cnt5)
`ifdef SYNC_FIFO_ERR_FLAGS_EN
        ,
        .i_err_clr      (clr5),
        .o_overflow     (ovf5),
        .o_underflow    (unf5)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge, then settle 1 ns so outputs are sampled away from the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [7:0] drain_exp [8];
    logic [1:0] ops [20];
    logic [7:0] q5 [$];
    logic [7:0] next5;

    initial begin
        rst_n = 1'b0;
        wr8 = 1'b0; rd8 = 1'b0; wd8 = '0;
        wr5 = 1'b0; rd5 = 1'b0; wd5 = '0;
`ifdef SYNC_FIFO_ERR_FLAGS_EN
        clr8 = 1'b0; clr5 = 1'b0;
`endif
        tick();
        tick();
        #2 rst_n = 1'b1;
        tick();

        // Reset state
        check("rst_empty", 32'(empty8), 1);
        check("rst_full", 32'(full8), 0);
        check("rst_count", 32'(cnt8), 0);
        check("rst_aempty", 32'(ae8), 1);
        check("rst_afull", 32'(af8), 0);
`ifdef SYNC_FIFO_ERR_FLAGS_EN
        check("rst_ovf", 32'(ovf8), 0);
        check("rst_unf", 32'(unf8), 0);
`endif

        // Fill 0x01..0x08
        for (int i = 1; i <= 8; i++) begin
            wr8 = 1'b1;
            wd8 = 8'(i);
            tick();
            check("fill_count", 32'(cnt8), i);
            check("fill_afull", 32'(af8), (i >= 7) ? 1 : 0);
            check("fill_full", 32'(full8), (i == 8) ? 1 : 0);
            check("fill_head", 32'(rdata8), 32'h01);
        end
        wr8 = 1'b0;

        // Push and pop together while full
        wr8 = 1'b1; wd8 = 8'hAA; rd8 = 1'b1;
        check("fullpp_head_before", 32'(rdata8), 32'h01);
        tick();
        wr8 = 1'b0; rd8 = 1'b0;
        check("fullpp_count", 32'(cnt8), 8);
        check("fullpp_full", 32'(full8), 1);
        check("fullpp_head_after", 32'(rdata8), 32'h02);

        // Drain: 0x02..0x08 then 0xAA
        drain_exp = '{8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'hAA};
        for (int i = 0; i < 8; i++) begin
            check("drain_data", 32'(rdata8), 32'(drain_exp[i]));
            check("drain_empty_before", 32'(empty8), 0);
            rd8 = 1'b1;
            tick();
            rd8 = 1'b0;
            check("drain_count", 32'(cnt8), 7 - i);
        end
        check("drain_empty", 32'(empty8), 1);
        check("drain_aempty", 32'(ae8), 1);
        check("drain_afull", 32'(af8), 0);

        // Pop while empty is ignored
        rd8 = 1'b1;
        tick();
        rd8 = 1'b0;
        check("pop_empty_count", 32'(cnt8), 0);
        check("pop_empty_empty", 32'(empty8), 1);
`ifdef SYNC_FIFO_ERR_FLAGS_EN
        check("unf_set", 32'(unf8), 1);
        clr8 = 1'b1;
        tick();
        clr8 = 1'b0;
        check("unf_clr", 32'(unf8), 0);
`endif

        // Push and pop while empty: push only, no bypass
        wr8 = 1'b1; wd8 = 8'h33; rd8 = 1'b1;
        tick();
        wr8 = 1'b0; rd8 = 1'b0;
        check("pp_empty_count", 32'(cnt8), 1);
        check("pp_empty_empty", 32'(empty8), 0);
        check("pp_empty_data", 32'(rdata8), 32'h33);
        rd8 = 1'b1;
        tick();
        rd8 = 1'b0;
        check("pp_empty_drain", 32'(empty8), 1);

        // Push while full without pop: data dropped
        for (int i = 0; i < 8; i++) begin
            wr8 = 1'b1;
            wd8 = 8'(8'h40 + i);
            tick();
        end
        wd8 = 8'h99;
        tick();
        wr8 = 1'b0;
        check("ovf_count", 32'(cnt8), 8);
        check("ovf_full", 32'(full8), 1);
`ifdef SYNC_FIFO_ERR_FLAGS_EN
        check("ovf_set", 32'(ovf8), 1);
        tick();
        check("ovf_hold", 32'(ovf8), 1);
        clr8 = 1'b1;
        tick();
        clr8 = 1'b0;
        check("ovf_clr", 32'(ovf8), 0);
`endif
        for (int i = 0; i < 8; i++) begin
            check("ovf_drain", 32'(rdata8), 32'(8'h40 + i));
            rd8 = 1'b1;
            tick();
            rd8 = 1'b0;
        end
        check("ovf_drain_empty", 32'(empty8), 1);

        // Wrap on Depth=5: preload 3, then 20 interleaved cycles holding 1..4 words
        next5 = 8'h20;
        for (int i = 0; i < 3; i++) begin
            wr5 = 1'b1; wd5 = next5;
            q5.push_back(next5);
            next5 = next5 + 8'h01;
            tick();
        end
        wr5 = 1'b0;
        check("wrap_pre_count", 32'(cnt5), 3);
        ops = '{2'b11, 2'b10, 2'b01, 2'b01, 2'b11, 2'b10, 2'b10, 2'b01, 2'b11, 2'b01,
                2'b01, 2'b10, 2'b11, 2'b10, 2'b11, 2'b01, 2'b10, 2'b11, 2'b01, 2'b01};
        for (int i = 0; i < 20; i++) begin
            check("wrap_head", 32'(rdata5), 32'(q5[0]));
            wr5 = ops[i][1];
            rd5 = ops[i][0];
            wd5 = next5;
            tick();
            if (ops[i][0]) void'(q5.pop_front());
            if (ops[i][1]) begin
                q5.push_back(next5);
                next5 = next5 + 8'h01;
            end
            wr5 = 1'b0; rd5 = 1'b0;
            check("wrap_count", 32'(cnt5), q5.size());
            check("wrap_full", 32'(full5), 0);
        end
        check("wrap_tail_head", 32'(rdata5), 32'(q5[0]));

        // Reset mid-stream
        for (int i = 0; i < 3; i++) begin
            wr8 = 1'b1; wd8 = 8'(8'h61 + i);
            tick();
        end
        wr8 = 1'b0;
        check("mid_count_before", 32'(cnt8), 3);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_empty", 32'(empty8), 1);
        check("mid_rst_count", 32'(cnt8), 0);
        check("mid_rst_aempty", 32'(ae8), 1);
        check("mid_rst_count5", 32'(cnt5), 0);
        tick();
        #2 rst_n = 1'b1;
        tick();
        wr8 = 1'b1; wd8 = 8'h55;
        tick();
        wr8 = 1'b0;
        check("post_rst_data", 32'(rdata8), 32'h55);
        check("post_rst_count", 32'(cnt8), 1);
        check("post_rst_empty", 32'(empty8), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
